// File: rtl/cxd2545_pkg.sv
// Shared definitions for the CXD2545 emulator SubQ output path.
//   state_e          : serializer sequencing states
//   SUBQ_NBITS       : bits in one SubQ frame
//   SCOR_CYCLES_DEF  : default SCOR high time in sys_clk cycles
//   TIMEOUT_DEF      : default SQCK inactivity limit in sys_clk cycles
package cxd2545_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCOR_HI = 2'd1,
        SHIFT   = 2'd2
    } state_e;

    localparam int SUBQ_NBITS      = 80;
    localparam int SCOR_CYCLES_DEF = 64;
    localparam int TIMEOUT_DEF     = 65535;

endpackage

// File: rtl/cxd2545_edge_det.sv
// Registered edge detector for an already-synchronised level input.
// The previous level is held in a flop; rise/fall are combinational
// comparisons of the current input against that flop.
//   clk          : clock
//   rst_n        : asynchronous active-low reset
//   sig          : level input
//   rise         : high for the cycle in which sig is 1 and was 0
//   fall         : high for the cycle in which sig is 0 and was 1
module cxd2545_edge_det
    import cxd2545_pkg::*;
#(
    // Idle level of the input; the previous-level flop resets to it so that
    // reset release never produces a spurious edge.
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_prev_q;
    logic sig_prev_d;

    always_comb begin
        sig_prev_d = sig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_prev_q <= RESET_LEVEL;
        end else begin
            sig_prev_q <= sig_prev_d;
        end
    end

    assign rise = sig & ~sig_prev_q;
    assign fall = ~sig & sig_prev_q;

endmodule

// File: rtl/cxd2545_subq_serializer.sv
// SubQ frame serializer: accepts one frame per sector into a pending buffer,
// announces it with SCOR, then shifts it out LSB first on SQSO, one bit per
// rising SQCK edge from the host. A second frame may be queued while the
// current one is shifting.
//   sys_clk      : system clock
//   reset_n      : asynchronous active-low reset
//   load_valid   : frame offered
//   load_data    : frame, bit 0 transmitted first
//   load_ready   : pending buffer empty (accept on load_valid && load_ready)
//   sqck         : host shift clock, synchronised, idle high
//   scor         : subcode sync flag
//   sqso         : serial SubQ data
//   busy         : not idle
//   frame_done   : one-cycle pulse after the last bit has been shifted
//   frame_abort  : one-cycle pulse when the host stops clocking mid-frame
module cxd2545_subq_serializer
    import cxd2545_pkg::*;
#(
    parameter int NBITS       = SUBQ_NBITS,
    parameter int SCOR_CYCLES = SCOR_CYCLES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [NBITS-1:0] load_data,
    output logic             load_ready,
    input  logic             sqck,
    output logic             scor,
    output logic             sqso,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_abort
);

    localparam int               CNT_W     = $clog2(NBITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NBITS);
    localparam logic [15:0]      TMO       = 16'(TIMEOUT);
    localparam logic [15:0]      SCOR_LAST = 16'(SCOR_CYCLES - 1);

    state_e             state_q, state_d;
    logic [NBITS-1:0]   shreg_q, shreg_d;
    logic [NBITS-1:0]   pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [15:0]        timer_q, timer_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;

    logic               sqck_rise;
    logic               sqck_fall_unused;
    logic [CNT_W-1:0]   bit_cnt_inc;
    logic [15:0]        timer_inc;

    cxd2545_edge_det #(
        .RESET_LEVEL (1'b1)
    ) u_sqck_edge (
        .clk   (sys_clk),
        .rst_n (reset_n),
        .sig   (sqck),
        .rise  (sqck_rise),
        .fall  (sqck_fall_unused)
    );

    assign load_ready  = ~pend_full_q;
    assign scor        = (state_q == SCOR_HI);
    assign busy        = (state_q != IDLE);
    // Data is only presented while a frame is active; IDLE forces 0 so stale
    // shift-register contents never leak onto the pin.
    assign sqso        = (state_q != IDLE) & shreg_q[0];
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        bit_cnt_d   = bit_cnt_q;
        timer_d     = timer_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;

        bit_cnt_inc = bit_cnt_q + 1'b1;
        // Saturating so a very large TIMEOUT can never be skipped by a wrap.
        timer_inc   = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

        // Loads only land while the buffer is empty, so this never collides
        // with IDLE draining the buffer in the same cycle.
        if (load_valid && load_ready) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (pend_full_q) begin
                    shreg_d     = pend_q;
                    pend_full_d = 1'b0;
                    bit_cnt_d   = '0;
                    timer_d     = '0;
                    state_d     = SCOR_HI;
                end
            end

            SCOR_HI, SHIFT: begin
                if (sqck_rise) begin
                    // An early host clock in SCOR_HI cuts SCOR short and
                    // consumes bit 0 exactly like a normal shift.
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = bit_cnt_inc;
                    timer_d   = '0;
                    state_d   = SHIFT;
                    if (bit_cnt_inc == LAST_CNT) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (state_q == SCOR_HI) begin
                    // timer doubles as the SCOR duration counter here
                    if (timer_q == SCOR_LAST) begin
                        timer_d = '0;
                        state_d = SHIFT;
                    end else begin
                        timer_d = timer_inc;
                    end
                end else if (timer_inc == TMO) begin
                    // Pending frame is kept; IDLE launches it next cycle.
                    abort_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pend_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_full_q <= pend_full_d;
            bit_cnt_q   <= bit_cnt_d;
            timer_q     <= timer_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
        end
    end

    // Frame data needs no reset: it is qualified by pend_full_q and state_q.
    always_ff @(posedge sys_clk) begin
        shreg_q <= shreg_d;
        pend_q  <= pend_d;
    end

endmodule

// File: tb/tb_cxd2545_subq_serializer.sv
module tb_cxd2545_subq_serializer;

    localparam int NB = 80;
    localparam int SC = 4;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          load_valid = 1'b0;
    logic [NB-1:0] load_data = '0;
    logic          load_ready;
    logic          sqck = 1'b1;
    logic          scor;
    logic          sqso;
    logic          busy;
    logic          frame_done;
    logic          frame_abort;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // scoreboard: expected SQSO bits in transmit order
    logic exp_q[$];

    int scor_cnt = 0;
    int scor_rise_cyc = -1;
    logic scor_prev = 1'b0;
    int done_cnt = 0;
    int done_cyc = -1;
    int abort_cnt = 0;
    int last_rise_cyc = 0;

    cxd2545_subq_serializer #(
        .NBITS       (NB),
        .SCOR_CYCLES (SC),
        .TIMEOUT     (TO)
    ) dut (
        .sys_clk     (clk),
        .reset_n     (reset_n),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .sqck        (sqck),
        .scor        (scor),
        .sqso        (sqso),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (scor) scor_cnt++;
        if (scor && !scor_prev) scor_rise_cyc = cyc;
        scor_prev = scor;
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (frame_abort) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // called at a falling clock edge; returns at a falling clock edge
    task automatic load_frame(input logic [NB-1:0] f);
        int n = 0;
        while (!load_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!load_ready) chk("load_ready_wait", 0, 1);
        load_valid = 1'b1;
        load_data  = f;
        @(negedge clk);
        load_valid = 1'b0;
        for (int b = 0; b < NB; b++) exp_q.push_back(f[b]);
    endtask

    task automatic wait_scor(input logic lvl, input string tag);
        int n = 0;
        while (scor !== lvl && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (scor !== lvl) chk(tag, scor, lvl);
    endtask

    // one host clock: low for l cycles, check the presented bit, rise, high for h cycles
    task automatic sq_pulse(input int h, input int l);
        logic e;
        sqck = 1'b0;
        repeat (l) @(negedge clk);
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("sqso_bit", sqso, e);
        end
        last_rise_cyc = cyc;
        sqck = 1'b1;
        repeat (h) @(negedge clk);
    endtask

    function automatic logic [NB-1:0] rnd_frame();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[NB-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int s0;
        int n;
        logic bad;
        logic e;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_scor", scor, 0);
        chk("rst_sqso", sqso, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_abort", frame_abort, 0);
        chk("rst_load_ready", load_ready, 1);
        reset_n = 1'b1;
        @(negedge clk);

        // idle noise: host clocks with nothing loaded
        bad = 1'b0;
        for (int p = 0; p < 10; p++) begin
            sqck = 1'b0;
            repeat (2) begin @(negedge clk); bad |= sqso | scor | busy; end
            sqck = 1'b1;
            repeat (2) begin @(negedge clk); bad |= sqso | scor | busy; end
        end
        chk("idle_noise_outputs", bad, 0);
        chk("idle_noise_ready", load_ready, 1);

        // single frame, slow host clock
        scor_cnt = 0;
        d0 = done_cnt;
        load_frame(80'h0123_4567_89AB_CDEF_0011);
        wait_scor(1'b1, "single_scor_rise");
        wait_scor(1'b0, "single_scor_fall");
        chk("single_scor_len", scor_cnt, SC);
        chk("single_busy", busy, 1);
        for (int p = 0; p < NB; p++) sq_pulse(20, 20);
        chk("single_done_cnt", done_cnt - d0, 1);
        chk("single_done_time", done_cyc, last_rise_cyc + 1);
        chk("single_sqso_after", sqso, 0);
        chk("single_busy_after", busy, 0);
        chk("single_sb_empty", exp_q.size(), 0);

        // early clock: rise in the 2nd SCOR cycle
        scor_cnt = 0;
        d0 = done_cnt;
        load_frame(rnd_frame());
        wait_scor(1'b1, "early_scor_rise");
        sqck = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        chk("early_bit0", sqso, e);
        sqck = 1'b1;
        @(negedge clk);
        chk("early_scor_drop", scor, 0);
        chk("early_scor_len", scor_cnt, 2);
        repeat (2) @(negedge clk);
        for (int p = 1; p < NB; p++) sq_pulse(3, 3);
        chk("early_done_cnt", done_cnt - d0, 1);
        chk("early_done_time", done_cyc, last_rise_cyc + 1);
        chk("early_sb_empty", exp_q.size(), 0);

        // back-to-back: B queued while A shifts
        d0 = done_cnt;
        load_frame(rnd_frame());
        wait_scor(1'b1, "b2b_a_scor_rise");
        wait_scor(1'b0, "b2b_a_scor_fall");
        for (int p = 0; p < 10; p++) sq_pulse(3, 3);
        load_frame(rnd_frame());
        chk("b2b_ready_low", load_ready, 0);
        for (int p = 10; p < NB; p++) sq_pulse(3, 3);
        chk("b2b_a_done", done_cnt - d0, 1);
        wait_scor(1'b0, "b2b_b_scor_fall");
        chk("b2b_b_scor_time", scor_rise_cyc, done_cyc + 1);
        chk("b2b_ready_back", load_ready, 1);
        for (int p = 0; p < NB; p++) sq_pulse(3, 3);
        chk("b2b_b_done", done_cnt - d0, 2);
        chk("b2b_sb_empty", exp_q.size(), 0);

        // timeout after 10 bits with a frame queued
        s0 = abort_cnt;
        d0 = done_cnt;
        load_frame(rnd_frame());
        wait_scor(1'b1, "tmo_scor_rise");
        wait_scor(1'b0, "tmo_scor_fall");
        for (int p = 0; p < 10; p++) sq_pulse(3, 3);
        load_frame(rnd_frame());
        n = 0;
        while (!frame_abort && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_abort_seen", frame_abort, 1);
        // rise is taken at the edge after last_rise_cyc; abort follows TO edges later
        chk("tmo_abort_time", cyc, last_rise_cyc + 1 + TO);
        chk("tmo_busy_idle", busy, 0);
        chk("tmo_sqso_idle", sqso, 0);
        @(negedge clk);
        chk("tmo_abort_once", abort_cnt - s0, 1);
        chk("tmo_next_scor", scor, 1);
        for (int k = 0; k < NB - 10; k++) e = exp_q.pop_front();
        wait_scor(1'b0, "tmo_next_scor_fall");
        for (int p = 0; p < NB; p++) sq_pulse(3, 3);
        chk("tmo_next_done", done_cnt - d0, 1);
        chk("tmo_sb_empty", exp_q.size(), 0);

        // reset mid-shift with a frame pending
        load_frame(rnd_frame());
        wait_scor(1'b1, "rst_scor_rise");
        wait_scor(1'b0, "rst_scor_fall");
        for (int p = 0; p < 40; p++) sq_pulse(3, 3);
        load_frame(rnd_frame());
        chk("rst_pending_full", load_ready, 0);
        #3;
        reset_n = 1'b0;
        #1;
        chk("rstm_scor", scor, 0);
        chk("rstm_sqso", sqso, 0);
        chk("rstm_busy", busy, 0);
        chk("rstm_done", frame_done, 0);
        chk("rstm_abort", frame_abort, 0);
        chk("rstm_load_ready", load_ready, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        s0 = scor_cnt;
        repeat (30) @(negedge clk);
        chk("rstm_no_scor", scor_cnt - s0, 0);
        chk("rstm_busy_after", busy, 0);
        d0 = done_cnt;
        load_frame(rnd_frame());
        wait_scor(1'b1, "rstm_new_scor_rise");
        chk("rstm_new_scor", scor, 1);
        wait_scor(1'b0, "rstm_new_scor_fall");
        for (int p = 0; p < NB; p++) sq_pulse(2, 2);
        chk("rstm_new_done", done_cnt - d0, 1);
        chk("rstm_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cxd2545_subq_serializer.md
Name: cxd2545_subq_serializer

Overview:
- Downstream output stage of the CXD2545 emulator's SubQ path. Receives one 80-bit SubQ frame per CD sector from the Nios-side frame source.
- Raises SCOR to announce the frame, then shifts it out on SQSO, one bit per host-driven SQCK edge.
- Feeds the top-level SCOR/SUBQ pins. The SOCT mux in front of those pins is outside this block.
- Double-buffered, so the next frame can be queued while the current one is shifting.

Parameters:
- NBITS, 80, bits per SubQ frame. Range 1..255.
- SCOR_CYCLES, 64, sys_clk cycles SCOR stays high before the block enters the shift phase.
- TIMEOUT, 65535, sys_clk cycles without an SQCK rising edge in the shift phase before the frame is aborted. Range 1..65535.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- load_valid  in  1  frame offered.
- load_data  in  NBITS  frame. Bit 0 is transmitted first.
- load_ready  out  1  pending buffer empty. A frame is accepted when load_valid && load_ready.
- sqck  in  1  SQCK, already synchronised upstream. Idle high.
- scor  out  1  subcode sync flag.
- sqso  out  1  serial SubQ data.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the last bit has been shifted.
- frame_abort  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset values:
  - Outputs: scor=0, sqso=0, busy=0, frame_done=0, frame_abort=0, load_ready=1.
  - Internal: state=IDLE, sqck_d=1, pending_full=0, bit_cnt=0, timer=0.
- Edge detect: rise = sqck && !sqck_d. sqck_d is registered every cycle.
- Pending buffer:
  - An accepted frame is latched into pend_reg and pending_full is set.
  - load_ready = !pending_full, registered-free (combinational from the flag).
- IDLE:
  - If pending_full: shreg <= pend_reg, clear pending_full, bit_cnt <= 0, timer <= 0, go to SCOR_HI.
  - This transfer takes one cycle. load_ready returns high in the following cycle.
  - A load accepted in that same following cycle is legal.
- SCOR_HI:
  - scor=1 and sqso=shreg[0].
  - After SCOR_CYCLES cycles, go to SHIFT with scor=0.
  - A rise during SCOR_HI ends SCOR immediately: shift once, bit_cnt=1, go to SHIFT.
- SHIFT:
  - sqso=shreg[0].
  - On rise: shreg >>= 1 (zero fill), bit_cnt++, timer cleared.
  - When bit_cnt reaches NBITS: pulse frame_done, sqso=0, go to IDLE.
  - Without a rise, timer increments. When timer reaches TIMEOUT: pulse frame_abort, sqso=0, go to IDLE. The pending frame is retained.
- Falling SQCK edges are ignored.
- SQCK rises while in IDLE are ignored. sqso stays 0.
- Back-to-back frames: if pending_full when returning to IDLE, the next SCOR_HI starts one cycle later.
- Simultaneous events:
  - A load accepted in the same cycle IDLE consumes pend_reg is impossible, because load_ready=0 that cycle.
  - frame_done has priority over timeout in the same cycle.
- Reset mid-frame: everything returns immediately to the reset values. pend_reg contents are discarded.
- Width rules:
  - bit_cnt is clog2(NBITS+1) bits.
  - timer is 16 bits, saturating; it never wraps.

Decomposition:
- Shared package cxd2545_pkg holds:
  - state typedef {IDLE, SCOR_HI, SHIFT};
  - SUBQ_NBITS=80;
  - default SCOR_CYCLES and TIMEOUT constants.
- One sub-module, cxd2545_edge_det (registered rise/fall detect, idle-high reset), reusable by the SENS/SOCT stages.

Test Plan:
- Single frame:
  - Stimulus: NBITS=80, SCOR_CYCLES=4, load 80'h0123_4567_89AB_CDEF_0011, then 80 SQCK pulses, 20 cycles high / 20 low.
  - Required: scor high exactly 4 cycles, sqso sequence equals load_data bits 0..79, frame_done pulses once after the 80th rise, sqso=0 afterwards.
- Early clock:
  - Stimulus: first SQCK rise 2 cycles into SCOR_HI.
  - Required: scor drops on the next cycle, bit 0 is consumed, and the total shifted count is still 80.
- Back-to-back:
  - Stimulus: load frame A, then frame B while A is shifting.
  - Required: load_ready=0 after B is accepted; B's SCOR rises 1 cycle after A's frame_done; B's bits are correct.
- Timeout:
  - Stimulus: TIMEOUT=100, stop SQCK after 10 bits.
  - Required: frame_abort pulses exactly 100 cycles after the last rise, state returns to IDLE, and a queued frame then starts normally.
- Reset mid-shift:
  - Stimulus: assert reset_n=0 asynchronously after 40 bits, with a frame pending.
  - Required: all outputs are at reset values within the same cycle, load_ready=1, and no SCOR appears after release until a new load.
- Idle noise:
  - Stimulus: 10 SQCK pulses with no frame loaded.
  - Required: sqso=0, scor=0, busy=0 throughout.
